// File: rtl/bresolve_train_pkg.sv
// Shared types and constants for the B-branch resolve/train back end.
package bresolve_train_pkg;

   localparam int unsigned PUSH_MAX     = 4;
   localparam int unsigned ENTRY_W      = 86;
   localparam int unsigned PC_W         = 32;
   localparam int unsigned HIST_W       = 8;
   localparam int unsigned SUM_W        = 11;
   localparam int unsigned ROW_W        = 2;
   localparam int unsigned WGT_W        = 8;
   localparam int unsigned ROWS         = 4;
   localparam int unsigned WPR          = 9;
   localparam int unsigned TRAIN_CYCLES = 9;
   localparam int unsigned J_W          = 4;

   localparam logic signed [WGT_W-1:0] WGT_MAX = 8'sh7F;
   localparam logic signed [WGT_W-1:0] WGT_MIN = 8'sh80;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_TRAIN = 2'd2
   } state_e;

   // Field order fixes the bit offsets: pred at bit 0 up to tgt at [85:54].
   typedef struct packed {
      logic [PC_W-1:0]   tgt;
      logic [PC_W-1:0]   ft;
      logic [SUM_W-1:0]  sum;
      logic [HIST_W-1:0] hist;
      logic [ROW_W-1:0]  row;
      logic              pred;
   } push_entry_t;

   function automatic logic signed [WGT_W-1:0] sat_step(input logic signed [WGT_W-1:0] w,
                                                       input logic up);
      if (up) return (w == WGT_MAX) ? w : w + 8'sd1;
      return (w == WGT_MIN) ? w : w - 8'sd1;
   endfunction

endpackage

// File: rtl/bresolve_train_if.sv
// Push / resolve / status bundle between the fetch/execute side and bresolve_train.
interface bresolve_train_if;
   import bresolve_train_pkg::*;

   logic [2:0]                    i_pushNum_3;
   logic [PUSH_MAX*ENTRY_W-1:0]   i_pushEntry_344;
   logic                          o_pushReady;
   logic                          i_resolveValid;
   logic                          i_resolveTaken;
   logic [PC_W-1:0]               i_resolveTarget_32;
   logic                          o_resolveReady;
   logic [PC_W-1:0]               o_correctPC_32;
   logic [2:0]                    o_counter_3;
   logic [7:0]                    o_pendingB_8;
   logic [ROWS*WPR*WGT_W-1:0]     o_weights_288;
   logic                          o_trainBusy;

   modport master (
      output i_pushNum_3, i_pushEntry_344, i_resolveValid, i_resolveTaken, i_resolveTarget_32,
      input  o_pushReady, o_resolveReady, o_correctPC_32, o_counter_3, o_pendingB_8,
             o_weights_288, o_trainBusy
   );

   modport slave (
      input  i_pushNum_3, i_pushEntry_344, i_resolveValid, i_resolveTaken, i_resolveTarget_32,
      output o_pushReady, o_resolveReady, o_correctPC_32, o_counter_3, o_pendingB_8,
             o_weights_288, o_trainBusy
   );

endinterface

// File: rtl/bresolve_pred_queue.sv
// Prediction queue: circular buffer with up-to-4 push, single pop and whole-queue flush.
module bresolve_pred_queue
   import bresolve_train_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [2:0]                    push_num_i,
   input  push_entry_t [PUSH_MAX-1:0]    push_entries_i,
   input  logic                          pop_i,
   input  logic                          flush_i,
   output push_entry_t                   head_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic                          push_ready_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   push_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              push_ok_c, pop_ok_c;

   assign push_ready_o = (CNT_W'(DEPTH) - cnt_q) >= CNT_W'(PUSH_MAX);
   assign push_ok_c    = !flush_i && push_ready_o && (push_num_i != 3'd0)
                         && (push_num_i <= 3'(PUSH_MAX));
   assign pop_ok_c     = !flush_i && pop_i && (cnt_q != '0);
   assign head_o       = mem_q[head_q];
   assign count_o      = cnt_q;

   // Pointer / occupancy next state; flush empties the queue by snapping head to tail.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         head_d = tail_q;
         cnt_d  = '0;
      end else begin
         if (pop_ok_c)  head_d = head_q + PTR_W'(1);
         if (push_ok_c) tail_d = tail_q + PTR_W'(push_num_i);
         cnt_d = cnt_q + (push_ok_c ? CNT_W'(push_num_i) : CNT_W'(0)) - CNT_W'(pop_ok_c);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok_c) begin
         for (int k = 0; k < int'(PUSH_MAX); k++) begin
            if (3'(k) < push_num_i) mem_q[tail_q + PTR_W'(k)] <= push_entries_i[k];
         end
      end
   end

endmodule

// File: rtl/bresolve_train.sv
// B-branch resolve, redirect and serial perceptron training. Define
// BRESOLVE_THRESHOLD_TRAIN_EN to also train on correct low-confidence predictions.
module bresolve_train
   import bresolve_train_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned THETA = 12
) (
   input  logic              i_clk,
   input  logic              i_rst,
   bresolve_train_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   state_e                    state_q, state_d;
   logic [J_W-1:0]            j_q, j_d;
   logic [ROW_W-1:0]          ctx_row_q, ctx_row_d;
   logic [HIST_W-1:0]         ctx_hist_q, ctx_hist_d;
   logic                      ctx_taken_q, ctx_taken_d;
   logic [PC_W-1:0]           correct_pc_q, correct_pc_d;
   logic                      counter_q, counter_d;
   logic signed [WGT_W-1:0]   w_q [ROWS][WPR];

   push_entry_t [PUSH_MAX-1:0] push_ents_c;
   push_entry_t               head_c;
   logic [CNT_W-1:0]          cnt_c;
   logic                      push_ready_c;
   logic                      accept_c, mispred_c, train_req_c, x_c;
   logic [PC_W-1:0]           fix_pc_c;

   assign push_ents_c = bus.i_pushEntry_344;

   bresolve_pred_queue #(.DEPTH(DEPTH)) u_queue (
      .clk_i          (i_clk),
      .rst_i          (i_rst),
      .push_num_i     (bus.i_pushNum_3),
      .push_entries_i (push_ents_c),
      .pop_i          (accept_c),
      .flush_i        (state_q == ST_FLUSH),
      .head_o         (head_c),
      .count_o        (cnt_c),
      .push_ready_o   (push_ready_c)
   );

   assign accept_c  = bus.i_resolveValid && (state_q == ST_IDLE) && (cnt_c != '0);
   assign mispred_c = (bus.i_resolveTaken != head_c.pred)
                      || (bus.i_resolveTaken && (bus.i_resolveTarget_32 != head_c.tgt));
   assign fix_pc_c  = bus.i_resolveTaken ? bus.i_resolveTarget_32 : head_c.ft;

`ifdef BRESOLVE_THRESHOLD_TRAIN_EN
   localparam logic signed [SUM_W-1:0] THETA_S = SUM_W'(THETA);
   assign train_req_c = !mispred_c && ($signed(head_c.sum) <= THETA_S)
                        && ($signed(head_c.sum) >= -THETA_S);
`else
   logic unused_sum;
   assign unused_sum  = ^{head_c.sum, SUM_W'(THETA)};
   assign train_req_c = 1'b0;
`endif

   // Input bit for the weight being trained; the bias sees a constant 1.
   assign x_c = (j_q == J_W'(WPR - 1)) ? 1'b1 : ctx_hist_q[j_q[2:0]];

   always_comb begin
      state_d      = state_q;
      j_d          = j_q;
      ctx_row_d    = ctx_row_q;
      ctx_hist_d   = ctx_hist_q;
      ctx_taken_d  = ctx_taken_q;
      correct_pc_d = '0;
      counter_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               counter_d   = 1'b1;
               ctx_row_d   = head_c.row;
               ctx_hist_d  = head_c.hist;
               ctx_taken_d = bus.i_resolveTaken;
               j_d         = '0;
               if (mispred_c) begin
                  correct_pc_d = fix_pc_c;
                  state_d      = ST_FLUSH;
               end else if (train_req_c) begin
                  state_d = ST_TRAIN;
               end
            end
         end
         ST_FLUSH: state_d = ST_TRAIN;
         ST_TRAIN: begin
            j_d = j_q + J_W'(1);
            if (j_q == J_W'(TRAIN_CYCLES - 1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         j_q          <= '0;
         ctx_row_q    <= '0;
         ctx_hist_q   <= '0;
         ctx_taken_q  <= 1'b0;
         correct_pc_q <= '0;
         counter_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         j_q          <= j_d;
         ctx_row_q    <= ctx_row_d;
         ctx_hist_q   <= ctx_hist_d;
         ctx_taken_q  <= ctx_taken_d;
         correct_pc_q <= correct_pc_d;
         counter_q    <= counter_d;
      end
   end

   // Weight file: one saturating +/-1 step per TRAIN cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int r = 0; r < int'(ROWS); r++)
            for (int c = 0; c < int'(WPR); c++)
               w_q[r][c] <= '0;
      end else if (state_q == ST_TRAIN) begin
         w_q[ctx_row_q][j_q] <= sat_step(w_q[ctx_row_q][j_q], ctx_taken_q == x_c);
      end
   end

   always_comb begin
      bus.o_weights_288 = '0;
      for (int r = 0; r < int'(ROWS); r++)
         for (int c = 0; c < int'(WPR); c++)
            bus.o_weights_288[r*int'(WPR*WGT_W) + c*int'(WGT_W) +: WGT_W] = w_q[r][c];
   end

   assign bus.o_pushReady    = push_ready_c;
   assign bus.o_resolveReady = (state_q == ST_IDLE) && (cnt_c != '0);
   assign bus.o_correctPC_32 = correct_pc_q;
   assign bus.o_counter_3    = {2'b00, counter_q};
   assign bus.o_pendingB_8   = 8'(cnt_c);
   assign bus.o_trainBusy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bresolve_train.sv
// Directed bench for bresolve_train: queue order, redirect, flush, training and saturation.
module tb_bresolve_train;

   logic clk;
   logic rst;
   int   n_total = 0;
   int   n_pass  = 0;

   bresolve_train_if bus();

   bresolve_train #(.DEPTH(8), .THETA(12)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp_v);
      n_total++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   function automatic logic [85:0] mk(input logic pred, input logic [1:0] row,
                                      input logic [7:0] hist, input logic [10:0] sum,
                                      input logic [31:0] ft, input logic [31:0] tgt);
      return {tgt, ft, sum, hist, row, pred};
   endfunction

   task automatic do_push(input int n, input logic [85:0] e0, input logic [85:0] e1,
                          input logic [85:0] e2, input logic [85:0] e3);
      bus.i_pushNum_3     = 3'(n);
      bus.i_pushEntry_344 = {e3, e2, e1, e0};
      @(posedge clk); #1;
      bus.i_pushNum_3     = 3'd0;
   endtask

   task automatic resolve(input logic taken, input logic [31:0] tgt);
      bus.i_resolveValid     = 1'b1;
      bus.i_resolveTaken     = taken;
      bus.i_resolveTarget_32 = tgt;
      @(posedge clk); #1;
      bus.i_resolveValid     = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.o_trainBusy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_timeout", 288'(bus.o_trainBusy), 288'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [85:0]  z;
      logic [287:0] w_exp;
      int           busy;
      z = '0;
      rst = 1'b1;
      bus.i_pushNum_3 = 3'd0;
      bus.i_pushEntry_344 = '0;
      bus.i_resolveValid = 1'b0;
      bus.i_resolveTaken = 1'b0;
      bus.i_resolveTarget_32 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_pending", 288'(bus.o_pendingB_8), 288'(0));
      check("rst_pc",      288'(bus.o_correctPC_32), 288'(0));
      check("rst_weights", bus.o_weights_288, 288'(0));
      check("rst_pushrdy", 288'(bus.o_pushReady), 288'(1));
      check("rst_busy",    288'(bus.o_trainBusy), 288'(0));
      check("rst_counter", 288'(bus.o_counter_3), 288'(0));

      // Four correct not-taken predictions
      do_push(4, mk(0, 0, 8'h00, 11'd40, 32'h100, 0), mk(0, 0, 8'h00, 11'd40, 32'h104, 0),
                 mk(0, 0, 8'h00, 11'd40, 32'h108, 0), mk(0, 0, 8'h00, 11'd40, 32'h10C, 0));
      check("push4_pending", 288'(bus.o_pendingB_8), 288'(4));
      check("push4_rslvrdy", 288'(bus.o_resolveReady), 288'(1));
      for (int k = 0; k < 4; k++) begin
         resolve(1'b0, 32'h0);
         check("nt_counter", 288'(bus.o_counter_3), 288'(1));
         check("nt_pending", 288'(bus.o_pendingB_8), 288'(3 - k));
         check("nt_pc",      288'(bus.o_correctPC_32), 288'(0));
         check("nt_busy",    288'(bus.o_trainBusy), 288'(0));
      end
      @(posedge clk); #1;
      check("nt_counter_idle", 288'(bus.o_counter_3), 288'(0));
      check("nt_weights",      bus.o_weights_288, 288'(0));

      // Not-taken predicted, taken actual: flush then train row 2
      do_push(1, mk(0, 2, 8'hA5, 11'd40, 32'h200, 0), z, z, z);
      resolve(1'b1, 32'h340);
      check("mp1_pc",      288'(bus.o_correctPC_32), 288'(32'h340));
      check("mp1_pending", 288'(bus.o_pendingB_8), 288'(0));
      check("mp1_rslvrdy", 288'(bus.o_resolveReady), 288'(0));
      busy = bus.o_trainBusy ? 1 : 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (c == 0) check("mp1_pc_clear", 288'(bus.o_correctPC_32), 288'(0));
         if (!bus.o_trainBusy) break;
         busy++;
      end
      check("mp1_busy_cycles", 288'(busy), 288'(10));
      w_exp = '0;
      w_exp[144 +: 72] = 72'h0101FF01FFFF01FF01;
      check("mp1_weights", bus.o_weights_288, w_exp);

      // Wrong target on a taken prediction; second entry and a FLUSH-cycle push discarded
      do_push(2, mk(1, 1, 8'h00, 11'd40, 32'h204, 32'h500),
                 mk(0, 0, 8'h00, 11'd40, 32'h300, 0), z, z);
      check("mp2_pre_pending", 288'(bus.o_pendingB_8), 288'(2));
      resolve(1'b1, 32'h540);
      check("mp2_pc",      288'(bus.o_correctPC_32), 288'(32'h540));
      check("mp2_pending", 288'(bus.o_pendingB_8), 288'(1));
      do_push(1, mk(0, 0, 8'h00, 11'd40, 32'h310, 0), z, z, z);
      check("mp2_flushed", 288'(bus.o_pendingB_8), 288'(0));
      check("mp2_busy",    288'(bus.o_trainBusy), 288'(1));
      wait_idle();
      w_exp[72 +: 72] = 72'h01FFFFFFFFFFFFFFFF;
      check("mp2_weights", bus.o_weights_288, w_exp);

      // Full-queue drop, simultaneous pop+push, wrap-around order
      do_push(4, mk(1, 3, 8'h00, 11'd40, 32'h700, 32'h1000), mk(1, 3, 8'h00, 11'd40, 32'h704, 32'h1010),
                 mk(1, 3, 8'h00, 11'd40, 32'h708, 32'h1020), mk(1, 3, 8'h00, 11'd40, 32'h70C, 32'h1030));
      do_push(1, mk(1, 3, 8'h00, 11'd40, 32'h710, 32'h1040), z, z, z);
      check("q_pending5", 288'(bus.o_pendingB_8), 288'(5));
      check("q_notready", 288'(bus.o_pushReady), 288'(0));
      do_push(4, mk(0, 3, 8'h00, 11'd40, 32'hBAD0, 0), mk(0, 3, 8'h00, 11'd40, 32'hBAD4, 0),
                 mk(0, 3, 8'h00, 11'd40, 32'hBAD8, 0), mk(0, 3, 8'h00, 11'd40, 32'hBADC, 0));
      check("q_dropped", 288'(bus.o_pendingB_8), 288'(5));
      resolve(1'b1, 32'h1000);
      check("q_pending4", 288'(bus.o_pendingB_8), 288'(4));
      check("q_ready4",   288'(bus.o_pushReady), 288'(1));
      bus.i_resolveValid     = 1'b1;
      bus.i_resolveTaken     = 1'b1;
      bus.i_resolveTarget_32 = 32'h1010;
      do_push(4, mk(1, 3, 8'h00, 11'd40, 32'h714, 32'h1050), mk(1, 3, 8'h00, 11'd40, 32'h718, 32'h1060),
                 mk(1, 3, 8'h00, 11'd40, 32'h71C, 32'h1070), mk(1, 3, 8'h00, 11'd40, 32'h720, 32'h1080));
      bus.i_resolveValid     = 1'b0;
      check("q_pushpop", 288'(bus.o_pendingB_8), 288'(7));
      check("q_pushpop_ctr", 288'(bus.o_counter_3), 288'(1));
      for (int k = 2; k <= 8; k++) begin
         resolve(1'b1, 32'h1000 + 32'(16 * k));
         check("q_order_pc",   288'(bus.o_correctPC_32), 288'(0));
         check("q_order_busy", 288'(bus.o_trainBusy), 288'(0));
      end
      check("q_drained", 288'(bus.o_pendingB_8), 288'(0));

      // Saturation at both limits
      for (int i = 0; i < 130; i++) begin
         do_push(1, mk(0, 0, 8'hFF, 11'd40, 32'h300, 0), z, z, z);
         resolve(1'b1, 32'h600);
         if (i == 0) check("sat_hi_pc", 288'(bus.o_correctPC_32), 288'(32'h600));
         wait_idle();
      end
      for (int i = 0; i < 130; i++) begin
         do_push(1, mk(1, 3, 8'hFF, 11'd40, 32'h304, 32'h800), z, z, z);
         resolve(1'b0, 32'h0);
         if (i == 0) check("sat_lo_pc", 288'(bus.o_correctPC_32), 288'(32'h304));
         wait_idle();
      end
      w_exp[0 +: 72]   = 72'h7F7F7F7F7F7F7F7F7F;
      w_exp[216 +: 72] = 72'h808080808080808080;
      check("sat_weights", bus.o_weights_288, w_exp);

      // Low-confidence correct prediction
      do_push(1, mk(0, 1, 8'h00, 11'd5, 32'h400, 0), z, z, z);
      resolve(1'b0, 32'h0);
      check("thr5_pc", 288'(bus.o_correctPC_32), 288'(0));
`ifdef BRESOLVE_THRESHOLD_TRAIN_EN
      check("thr5_busy", 288'(bus.o_trainBusy), 288'(1));
      wait_idle();
      w_exp[72 +: 72] = 72'h0;
      check("thr5_weights", bus.o_weights_288, w_exp);
      do_push(1, mk(0, 1, 8'h00, 11'h7F4, 32'h404, 0), z, z, z);
      resolve(1'b0, 32'h0);
      check("thrm12_busy", 288'(bus.o_trainBusy), 288'(1));
      wait_idle();
      w_exp[72 +: 72] = 72'hFF0101010101010101;
      check("thrm12_weights", bus.o_weights_288, w_exp);
`else
      check("thr5_busy", 288'(bus.o_trainBusy), 288'(0));
      check("thr5_weights", bus.o_weights_288, w_exp);
`endif
      do_push(1, mk(0, 1, 8'h00, 11'd40, 32'h408, 0), z, z, z);
      resolve(1'b0, 32'h0);
      check("thr40_busy", 288'(bus.o_trainBusy), 288'(0));
      @(posedge clk); #1;
      check("thr40_weights", bus.o_weights_288, w_exp);

      // Reset in the middle of training
      do_push(1, mk(0, 2, 8'hA5, 11'd40, 32'h200, 0), z, z, z);
      resolve(1'b1, 32'h340);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mrst_weights", bus.o_weights_288, 288'(0));
      check("mrst_busy",    288'(bus.o_trainBusy), 288'(0));
      check("mrst_pending", 288'(bus.o_pendingB_8), 288'(0));
      check("mrst_pc",      288'(bus.o_correctPC_32), 288'(0));
      check("mrst_pushrdy", 288'(bus.o_pushReady), 288'(1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
